// File: rtl/div_seq.sv
// Multi-cycle 32-bit integer divider (DIV/DIVU) for the EX stage: restoring
// shift-subtract, one quotient bit per cycle, result held in END until start drops.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  signed_q, signed_d;
  logic                  op1_neg_q, op1_neg_d;
  logic                  op2_neg_q, op2_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic                  accept;
  logic [DATA_W:0]       shifted_hi;
  logic [DATA_W:0]       diff;
  logic [2*DATA_W:0]     step_next;
  logic                  neg_quot;
  logic                  neg_rem;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic is_signed);
    logic signed [DATA_W-1:0] neg_v;
    neg_v = -v;
    return (is_signed && v[DATA_W-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    logic [DATA_W-1:0] twos;
    twos = ~v + 1'b1;
    return neg ? twos : v;
  endfunction

  assign accept = start_i && !annul_i;

  // Restoring step: shift left, trial-subtract divisor from the upper 33 bits.
  assign shifted_hi = work_q[2*DATA_W-1:DATA_W-1];
  assign diff       = shifted_hi - {1'b0, divisor_q};
  assign step_next  = diff[DATA_W] ? {shifted_hi, work_q[DATA_W-2:0], 1'b0}
                                   : {diff,       work_q[DATA_W-2:0], 1'b1};

  assign neg_quot = signed_q && (op1_neg_q ^ op2_neg_q);
  assign neg_rem  = signed_q && op1_neg_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = (opdata2_i == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)                 state_d = S_IDLE;
        else if (cnt_q == LAST_STEP) state_d = S_END;
      end
      S_END:     state_d = (annul_i || !start_i) ? S_IDLE : S_END;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; stall is masked during reset since start_i may already be high
  always_comb begin
    ready_o     = (state_q == S_END);
    result_o    = ready_o ? result_q : '0;
    stall_req_o = !rst && ((state_q == S_ON) || (state_q == S_DIVZERO) ||
                           ((state_q == S_IDLE) && accept));
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    op1_neg_d = op1_neg_q;
    op2_neg_d = op2_neg_q;
    result_d  = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          signed_d  = signed_i;
          op1_neg_d = opdata1_i[DATA_W-1];
          op2_neg_d = opdata2_i[DATA_W-1];
          work_d    = {{(DATA_W+1){1'b0}}, magnitude(opdata1_i, signed_i)};
          divisor_d = magnitude(opdata2_i, signed_i);
          cnt_d     = '0;
          result_d  = '0;
        end
      end
      S_DIVZERO: result_d = '0;
      S_ON: begin
        work_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP)
          result_d = {apply_sign(step_next[2*DATA_W-1:DATA_W], neg_rem),
                      apply_sign(step_next[DATA_W-1:0], neg_quot)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      op1_neg_q <= op1_neg_d;
      op2_neg_q <= op2_neg_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table of divides plus annul and reset sequences.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  int tests_run = 0;
  int tests_failed = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input int lat);
    int edges;
    int stalls;
    @(negedge clk);
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    stalls = stall_req_o ? 1 : 0;
    edges  = 0;
    while (ready_o !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        // operands are scrambled after acceptance and must not matter
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
      end
      if (ready_o !== 1'b1 && stall_req_o === 1'b1) stalls++;
    end
    check({name, " latency"}, 64'(edges), 64'(lat));
    check({name, " result"}, result_o, res);
    check({name, " stall cycles"}, 64'(stalls), 64'(lat));
    check({name, " stall in END"}, 64'(stall_req_o), 64'd0);
    @(posedge clk);
    #1;
    check({name, " held in END"}, {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " idle ready"}, {63'd0, ready_o}, 64'd0);
    check({name, " idle result"}, result_o, 64'd0);
  endtask

  initial begin
    int ready_seen;

    vecs[0]  = '{"u100/7",    1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                33};
    vecs[1]  = '{"s-7/2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   {32'hFFFFFFFF, 32'hFFFFFFFD},   33};
    vecs[2]  = '{"s_min/-1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000},   33};
    vecs[3]  = '{"u5/0",      1'b0, 32'd5,          32'd0,          64'h0,                          2};
    vecs[4]  = '{"u9/3",      1'b0, 32'd9,          32'd3,          {32'd0, 32'd3},                 33};
    vecs[5]  = '{"umax/1",    1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},          33};
    vecs[6]  = '{"s7/-2",     1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          33};
    vecs[7]  = '{"s-7/-2",    1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},          33};
    vecs[8]  = '{"u-7raw/2",  1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},          33};
    vecs[9]  = '{"u3/10",     1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                 33};
    vecs[10] = '{"s_min/1",   1'b1, 32'h80000000,   32'd1,          {32'd0, 32'h80000000},          33};
    vecs[11] = '{"s0/0",      1'b1, 32'd0,          32'd0,          64'h0,                          2};
    vecs[12] = '{"uDEADBEEF/16", 1'b0, 32'hDEADBEEF, 32'h10,        {32'hF, 32'h0DEADBEE},          33};

    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Annul when cnt==10 (after the 11th edge counting the accepting edge)
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul ready", {63'd0, ready_o}, 64'd0);
    check("annul stall", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1 || stall_req_o === 1'b1) ready_seen++;
    end
    check("annul quiet", 64'(ready_seen), 64'd0);
    run_div("post-annul u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Annul while in END drops the result at once
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("divzero ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul END ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;

    // Asynchronous reset mid-ON
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midON rst ready", {63'd0, ready_o}, 64'd0);
    check("midON rst result", result_o, 64'd0);
    check("midON rst stall", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1 || stall_req_o === 1'b1 || result_o !== 64'd0) ready_seen++;
    end
    check("post-reset idle", 64'(ready_seen), 64'd0);
    run_div("post-reset u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
